// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Zero-latency lookup from fetch PC; trained one update per cycle from execute.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [IDX-1:0]  w_upd_idx;
  logic [TAGW-1:0] w_upd_tag;
  logic            w_upd_hit;
  logic [1:0]      w_ctr_cur;
  logic [1:0]      w_ctr_nxt;
  logic            w_unused;

  // Instructions are word aligned, so PC[1:0] never participates.
  assign w_unused  = ^{if_pc[1:0], upd_pc[1:0]};

  assign w_idx     = if_pc[IDX+1:2];
  assign w_tag     = if_pc[XLEN-1:IDX+2];
  assign w_upd_idx = upd_pc[IDX+1:2];
  assign w_upd_tag = upd_pc[XLEN-1:IDX+2];

  assign pred_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign pred_taken  = pred_hit && r_ctr[w_idx][1];
  assign pred_target = pred_taken ? r_target[w_idx] : (if_pc + XLEN'(4));

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_ctr_cur = r_ctr[w_upd_idx];

  // Saturating counter step toward the resolved outcome.
  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'd1;
    end
  end

  // Hits train the counter; taken misses (including aliases) allocate fresh at weak-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_ctr_nxt;
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor (ENTRIES=16, XLEN=32).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int n_cmp;
  int n_err;

  branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [31:0] upc;
    logic        tk;
    logic [31:0] utgt;
    logic [31:0] lpc;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(logic en, logic [31:0] upc, logic tk, logic [31:0] utgt,
                              logic [31:0] lpc, logic eh, logic et, logic [31:0] etgt);
    vec_t v;
    v.en = en; v.upc = upc; v.tk = tk; v.utgt = utgt;
    v.lpc = lpc; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_look(input string name, input logic eh, input logic et, input logic [31:0] etgt);
    chk({name, ".hit"},    32'(pred_hit),   32'(eh));
    chk({name, ".taken"},  32'(pred_taken), 32'(et));
    chk({name, ".target"}, pred_target,     etgt);
  endtask

  task automatic idle_upd();
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if_pc = 32'h100;
    idle_upd();

    // Each row: lookup checked against current state, then the update lands at the next edge.
    vecs[0]  = mk(0, 32'h0,   0, 32'h0,    32'h100,      0, 0, 32'h104);
    vecs[1]  = mk(0, 32'h0,   0, 32'h0,    32'hFFFFFFFC, 0, 0, 32'h0);
    vecs[2]  = mk(1, 32'h100, 1, 32'h80,   32'h100,      0, 0, 32'h104);
    vecs[3]  = mk(0, 32'h0,   0, 32'h0,    32'h100,      1, 1, 32'h80);
    vecs[4]  = mk(1, 32'h100, 0, 32'hDEAD, 32'h100,      1, 1, 32'h80);
    vecs[5]  = mk(1, 32'h100, 0, 32'h0,    32'h100,      1, 0, 32'h104);
    vecs[6]  = mk(1, 32'h100, 0, 32'h0,    32'h100,      1, 0, 32'h104);
    vecs[7]  = mk(0, 32'h0,   0, 32'h0,    32'h100,      1, 0, 32'h104);
    vecs[8]  = mk(1, 32'h100, 1, 32'h90,   32'h100,      1, 0, 32'h104);
    vecs[9]  = mk(1, 32'h100, 1, 32'h90,   32'h100,      1, 0, 32'h104);
    vecs[10] = mk(1, 32'h100, 1, 32'h90,   32'h100,      1, 1, 32'h90);
    vecs[11] = mk(1, 32'h100, 1, 32'hA0,   32'h100,      1, 1, 32'h90);
    vecs[12] = mk(1, 32'h100, 0, 32'h0,    32'h100,      1, 1, 32'hA0);
    vecs[13] = mk(0, 32'h0,   0, 32'h0,    32'h100,      1, 1, 32'hA0);
    vecs[14] = mk(1, 32'h100, 0, 32'h0,    32'h100,      1, 1, 32'hA0);
    vecs[15] = mk(0, 32'h0,   0, 32'h0,    32'h103,      1, 0, 32'h107);
    vecs[16] = mk(0, 32'h100, 1, 32'h44,   32'h100,      1, 0, 32'h104);
    vecs[17] = mk(0, 32'h0,   0, 32'h0,    32'h100,      1, 0, 32'h104);
    vecs[18] = mk(1, 32'h500, 1, 32'h40,   32'h500,      0, 0, 32'h504);
    vecs[19] = mk(0, 32'h0,   0, 32'h0,    32'h100,      0, 0, 32'h104);
    vecs[20] = mk(0, 32'h0,   0, 32'h0,    32'h500,      1, 1, 32'h40);
    vecs[21] = mk(1, 32'h208, 0, 32'h60,   32'h208,      0, 0, 32'h20C);
    vecs[22] = mk(0, 32'h0,   0, 32'h0,    32'h208,      0, 0, 32'h20C);
    vecs[23] = mk(0, 32'h208, 1, 32'h60,   32'h208,      0, 0, 32'h20C);
    vecs[24] = mk(0, 32'h0,   0, 32'h0,    32'h208,      0, 0, 32'h20C);
    vecs[25] = mk(1, 32'h100, 0, 32'h0,    32'h500,      1, 1, 32'h40);
    vecs[26] = mk(0, 32'h0,   0, 32'h0,    32'h500,      1, 1, 32'h40);

    repeat (2) @(negedge clk);
    #1;
    chk_look("in_reset", 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_pc      = vecs[i].lpc;
      upd_en     = vecs[i].en;
      upd_pc     = vecs[i].upc;
      upd_taken  = vecs[i].tk;
      upd_target = vecs[i].utgt;
      #1;
      chk_look($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etgt);
    end

    // Populate several entries, then pulse reset between edges with an update pending.
    @(negedge clk); upd_en = 1'b1; upd_pc = 32'h10C; upd_taken = 1'b1; upd_target = 32'h1000;
    @(negedge clk); upd_pc = 32'h110; upd_target = 32'h2000;
    @(negedge clk); upd_pc = 32'h7F0; upd_target = 32'h3000;
    @(negedge clk); idle_upd(); if_pc = 32'h10C;
    #1; chk_look("pre_rst_10c", 1'b1, 1'b1, 32'h1000);
    if_pc = 32'h7F0;
    #1; chk_look("pre_rst_7f0", 1'b1, 1'b1, 32'h3000);
    upd_en = 1'b1; upd_pc = 32'h114; upd_taken = 1'b1; upd_target = 32'h4000;
    if_pc = 32'h10C;
    #1;
    rst = 1'b1;
    #1; chk_look("async_rst", 1'b0, 1'b0, 32'h110);
    @(negedge clk);
    idle_upd();
    rst = 1'b0;
    #1;
    begin
      logic [31:0] pcs [6];
      pcs[0] = 32'h10C; pcs[1] = 32'h110; pcs[2] = 32'h7F0;
      pcs[3] = 32'h500; pcs[4] = 32'h114; pcs[5] = 32'h100;
      for (int k = 0; k < 6; k++) begin
        if_pc = pcs[k];
        #1;
        chk_look($sformatf("post_rst_%h", pcs[k]), 1'b0, 1'b0, pcs[k] + 32'd4);
      end
    end

    // Taken branch at the top of memory: allocation then wrap-free taken target.
    @(negedge clk); upd_en = 1'b1; upd_pc = 32'hFFFFFFFC; upd_taken = 1'b1; upd_target = 32'h200;
    @(negedge clk); idle_upd(); if_pc = 32'hFFFFFFFC;
    #1; chk_look("top_pc_alloc", 1'b1, 1'b1, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
